// File: rtl/rom_table.sv
// rom_table: 16 x 8 seven-segment digit decoder ROM.
// Addresses 0..NUM_ENTRIES-1 hold segment codes {dp,g,f,e,d,c,b,a} (active-high);
// all other addresses read 0x00 and raise oob. Reads are registered with
// one cycle of latency and a single-cycle valid strobe.
module rom_table #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int NUM_ENTRIES = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              oob
);

  logic [DATA_W-1:0] rom_word;
  logic              in_range;

  logic [DATA_W-1:0] data_q,  data_d;
  logic              valid_q, valid_d;
  logic              oob_q,   oob_d;

  assign in_range = (address < ADDR_W'(NUM_ENTRIES));

  // Constant digit lookup; the default arm keeps every address defined.
  always_comb begin
    rom_word = '0;
    case (address)
      ADDR_W'(0): rom_word = DATA_W'(8'h3F);
      ADDR_W'(1): rom_word = DATA_W'(8'h06);
      ADDR_W'(2): rom_word = DATA_W'(8'h5B);
      ADDR_W'(3): rom_word = DATA_W'(8'h4F);
      ADDR_W'(4): rom_word = DATA_W'(8'h66);
      ADDR_W'(5): rom_word = DATA_W'(8'h6D);
      ADDR_W'(6): rom_word = DATA_W'(8'h7D);
      ADDR_W'(7): rom_word = DATA_W'(8'h07);
      ADDR_W'(8): rom_word = DATA_W'(8'h7F);
      ADDR_W'(9): rom_word = DATA_W'(8'h6F);
      default:    rom_word = '0;
    endcase
  end

  // Next-state: an accepted read loads data/oob and strobes valid; idle cycles hold data/oob.
  always_comb begin
    data_d  = data_q;
    oob_d   = oob_q;
    valid_d = 1'b0;
    if (rd_en) begin
      data_d  = in_range ? rom_word : '0;
      oob_d   = ~in_range;
      valid_d = 1'b1;
    end
  end

  // Output registers; synchronous reset wins over a read presented on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      oob_q   <= oob_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign oob   = oob_q;

endmodule

// File: tb/tb_rom_table.sv
// tb_rom_table: directed plus randomized checking of rom_table against a
// behavioural model that builds segment codes from lit-segment lists.
module tb_rom_table;

  logic       clk;
  logic       rst_n;
  logic       rd_en;
  logic [3:0] address;
  logic [7:0] data;
  logic       valid;
  logic       oob;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  logic [7:0] exp_data  = '0;
  logic       exp_valid = 1'b0;
  logic       exp_oob   = 1'b0;

  rom_table #(.ADDR_W(4), .DATA_W(8), .NUM_ENTRIES(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (rd_en),
    .address (address),
    .data    (data),
    .valid   (valid),
    .oob     (oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment code for a digit, built from which of segments a..g are lit.
  function automatic logic [7:0] seg_code(input int d);
    string s;
    logic [7:0] c;
    case (d)
      0: s = "abcdef";
      1: s = "bc";
      2: s = "abdeg";
      3: s = "abcdg";
      4: s = "bcfg";
      5: s = "acdfg";
      6: s = "acdefg";
      7: s = "abc";
      8: s = "abcdefg";
      9: s = "abcdfg";
      default: s = "";
    endcase
    c = '0;
    for (int k = 0; k < s.len(); k++) c[s[k] - "a"] = 1'b1;
    return c;
  endfunction

  // Model: what the outputs must be after each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_data = '0; exp_valid = 1'b0; exp_oob = 1'b0;
    end else if (rd_en) begin
      exp_valid = 1'b1;
      exp_oob   = (int'(address) >= 10);
      exp_data  = exp_oob ? 8'h00 : seg_code(int'(address));
    end else begin
      exp_valid = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (data !== exp_data) begin
        n_fail++;
        $display("FAIL model_data t=%0t got=%02h want=%02h", $time, data, exp_data);
      end
      n_checks++;
      if (valid !== exp_valid) begin
        n_fail++;
        $display("FAIL model_valid t=%0t got=%0b want=%0b", $time, valid, exp_valid);
      end
      n_checks++;
      if (oob !== exp_oob) begin
        n_fail++;
        $display("FAIL model_oob t=%0t got=%0b want=%0b", $time, oob, exp_oob);
      end
    end
  end

  task automatic step(input logic r, input logic en, input logic [3:0] a);
    rst_n = r; rd_en = en; address = a;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%02h want=%02h", name, got, want);
    end
  endtask

  logic [7:0] lit_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  initial begin
    rst_n = 1'b0; rd_en = 1'b1; address = 4'd3;
    // Reset held two cycles with a read pending.
    step(1'b0, 1'b1, 4'd3);
    chk_en = 1;
    step(1'b0, 1'b1, 4'd3);
    chk("reset_data", data, 8'h00);
    chk("reset_valid", {7'd0, valid}, 8'h00);
    chk("reset_oob", {7'd0, oob}, 8'h00);

    // Sweep populated addresses back to back.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 4'(i));
      chk($sformatf("sweep_data_%0d", i), data, lit_tab[i]);
      chk($sformatf("sweep_valid_%0d", i), {7'd0, valid}, 8'h01);
      chk($sformatf("sweep_oob_%0d", i), {7'd0, oob}, 8'h00);
    end

    // Out-of-bounds reads, then back in range.
    step(1'b1, 1'b1, 4'd10);
    chk("oob10_data", data, 8'h00);
    chk("oob10_flag", {7'd0, oob}, 8'h01);
    chk("oob10_valid", {7'd0, valid}, 8'h01);
    step(1'b1, 1'b1, 4'd15);
    chk("oob15_data", data, 8'h00);
    chk("oob15_flag", {7'd0, oob}, 8'h01);
    step(1'b1, 1'b1, 4'd8);
    chk("after_oob_data", data, 8'h7F);
    chk("after_oob_flag", {7'd0, oob}, 8'h00);

    // Hold: data persists while rd_en is low and address moves.
    step(1'b1, 1'b1, 4'd4);
    chk("hold_load", data, 8'h66);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'd2);
      chk($sformatf("hold_data_%0d", i), data, 8'h66);
      chk($sformatf("hold_valid_%0d", i), {7'd0, valid}, 8'h00);
    end

    // Mid-stream reset discards the read presented with it.
    step(1'b1, 1'b1, 4'd5);
    step(1'b1, 1'b1, 4'd6);
    step(1'b0, 1'b1, 4'd7);
    chk("midrst_data", data, 8'h00);
    chk("midrst_valid", {7'd0, valid}, 8'h00);
    chk("midrst_oob", {7'd0, oob}, 8'h00);
    step(1'b1, 1'b1, 4'd7);
    chk("post_rst_data", data, 8'h07);
    chk("post_rst_valid", {7'd0, valid}, 8'h01);

    // Single-cycle strobe.
    step(1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 4'd1);
    chk("strobe_data", data, 8'h06);
    chk("strobe_valid_hi", {7'd0, valid}, 8'h01);
    step(1'b1, 1'b0, 4'd1);
    chk("strobe_valid_lo", {7'd0, valid}, 8'h00);
    chk("strobe_data_hold", data, 8'h06);

    // Randomized traffic checked by the model each cycle.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
